// File: rtl/countdown_pkg.sv
// rtl/countdown_pkg.sv - shared countdown types and defaults
package countdown_pkg;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    WARN = 2'd1,
    OVER = 2'd2
  } state_t;

  // Defaults shared with the countdown timer so both ends agree on the round length
  localparam int START_VALUE_DEF = 40;
  localparam int WARN_THRESH_DEF = 10;

  localparam int ELAPSED_W = 7;
  localparam logic [ELAPSED_W-1:0] ELAPSED_MAX = '1;
  localparam logic [ELAPSED_W-1:0] ELAPSED_ONE = 1;

endpackage

// File: rtl/bin_to_bcd6.sv
// rtl/bin_to_bcd6.sv - combinational 6-bit binary to two BCD digits
module bin_to_bcd6 (
  input  logic [5:0] bin,
  output logic [3:0] tens,
  output logic [3:0] ones
);

  logic [13:0] sh;

  // Double-dabble: add 3 to any digit >= 5 before each left shift
  always_comb begin
    sh = {8'd0, bin};
    for (int i = 0; i < 6; i++) begin
      if (sh[9:6] >= 4'd5)   sh[9:6]   = sh[9:6] + 4'd3;
      if (sh[13:10] >= 4'd5) sh[13:10] = sh[13:10] + 4'd3;
      sh = sh << 1;
    end
    tens = sh[13:10];
    ones = sh[9:6];
  end

endmodule

// File: rtl/countdown_monitor.sv
// rtl/countdown_monitor.sv - samples countdown value and end flag, drives display/control outputs
module countdown_monitor
  import countdown_pkg::*;
#(
  parameter int START_VALUE = START_VALUE_DEF,
  parameter int WARN_THRESH = WARN_THRESH_DEF,
  parameter int TW          = 6
) (
  input  logic                 timer_clk,
  input  logic                 rst,
  input  logic [TW-1:0]        time_remaining,
  input  logic                 game_end,
  output logic [3:0]           tens,
  output logic [3:0]           ones,
  output logic                 warn,
  output logic                 blink,
  output logic                 over_pulse,
  output logic                 over,
  output logic [ELAPSED_W-1:0] elapsed,
  output logic                 proto_err
);

  localparam logic [TW-1:0] START_T = TW'(START_VALUE);
  localparam logic [TW-1:0] WARN_T  = TW'(WARN_THRESH);
  localparam logic [TW-1:0] ONE_T   = 1;
  localparam logic [3:0]    START_TENS = 4'(START_VALUE / 10);
  localparam logic [3:0]    START_ONES = 4'(START_VALUE % 10);

  logic [TW-1:0] time_q;
  logic          end_q;
  state_t        state;
  state_t        state_nxt;

  logic          is_hold;
  logic          is_dec;
  logic          is_reload;
  logic          is_err;

  logic [5:0]    bcd_in;
  logic [3:0]    tens_c;
  logic [3:0]    ones_c;

  assign bcd_in = 6'(time_remaining);

  bin_to_bcd6 u_bcd (
    .bin  (bcd_in),
    .tens (tens_c),
    .ones (ones_c)
  );

  // A step down from 0 is not a decrement; it would otherwise wrap to the max value
  always_comb begin
    is_hold   = (time_remaining == time_q);
    is_dec    = (time_q != '0) && (time_remaining == time_q - ONE_T);
    is_reload = (time_remaining == START_T) && (time_remaining > time_q);
    is_err    = !(is_hold || is_dec || is_reload);
  end

  always_comb begin
    state_nxt = state;
    if (is_reload) begin
      state_nxt = RUN;
    end else begin
      case (state)
        RUN, WARN: begin
          if (game_end || time_remaining == '0)
            state_nxt = OVER;
          else if (time_remaining <= WARN_T)
            state_nxt = WARN;
          else
            state_nxt = RUN;
        end
        OVER:    state_nxt = OVER;
        default: state_nxt = RUN;
      endcase
    end
  end

  always_ff @(posedge timer_clk) begin
    if (rst) begin
      time_q     <= START_T;
      end_q      <= 1'b0;
      state      <= RUN;
      tens       <= START_TENS;
      ones       <= START_ONES;
      warn       <= 1'b0;
      blink      <= 1'b0;
      over_pulse <= 1'b0;
      over       <= 1'b0;
      elapsed    <= '0;
      proto_err  <= 1'b0;
    end else begin
      time_q     <= time_remaining;
      end_q      <= game_end;
      state      <= state_nxt;
      tens       <= tens_c;
      ones       <= ones_c;
      warn       <= (state_nxt == WARN);
      over       <= (state_nxt == OVER);
      // Blink starts low on the entry edge and toggles while WARN persists
      blink      <= (state_nxt == WARN) && (state == WARN) && !blink;
      over_pulse <= game_end && !end_q;
      if (is_reload)
        elapsed <= '0;
      else if (is_dec && elapsed != ELAPSED_MAX)
        elapsed <= elapsed + ELAPSED_ONE;
      if (is_err)
        proto_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_countdown_monitor.sv
// tb/tb_countdown_monitor.sv - directed self-checking bench for countdown_monitor
module tb_countdown_monitor;

  logic       timer_clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] time_remaining = 6'd40;
  logic       game_end = 1'b0;
  logic [3:0] tens;
  logic [3:0] ones;
  logic       warn;
  logic       blink;
  logic       over_pulse;
  logic       over;
  logic [6:0] elapsed;
  logic       proto_err;

  int checks = 0;
  int failures = 0;

  countdown_monitor #(.START_VALUE(40), .WARN_THRESH(10), .TW(6)) dut (
    .timer_clk      (timer_clk),
    .rst            (rst),
    .time_remaining (time_remaining),
    .game_end       (game_end),
    .tens           (tens),
    .ones           (ones),
    .warn           (warn),
    .blink          (blink),
    .over_pulse     (over_pulse),
    .over           (over),
    .elapsed        (elapsed),
    .proto_err      (proto_err)
  );

  always #5 timer_clk = ~timer_clk;

  task automatic drive(input int t, input logic g);
    time_remaining = 6'(t);
    game_end = g;
    @(posedge timer_clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    drive(40, 1'b0);
    drive(40, 1'b0);
    checks++; if (tens !== 4'd4) begin failures++; $display("FAIL reset_tens got=%0d exp=4", tens); end
    checks++; if (ones !== 4'd0) begin failures++; $display("FAIL reset_ones got=%0d exp=0", ones); end
    checks++; if ({warn, blink, over, over_pulse, proto_err} !== 5'b0) begin
      failures++; $display("FAIL reset_flags got=%b exp=00000", {warn, blink, over, over_pulse, proto_err});
    end
    checks++; if (elapsed !== 7'd0) begin failures++; $display("FAIL reset_elapsed got=%0d exp=0", elapsed); end
    rst = 1'b0;
  endtask

  task automatic test_countdown;
    logic exp_warn;
    logic exp_blink;
    drive(40, 1'b0);
    for (int v = 39; v >= 0; v--) begin
      drive(v, v == 0);
      exp_warn  = (v >= 1 && v <= 10);
      exp_blink = exp_warn ? 1'((10 - v) % 2) : 1'b0;
      checks++; if (tens !== 4'(v / 10) || ones !== 4'(v % 10)) begin
        failures++; $display("FAIL cd_bcd v=%0d got=%0d/%0d exp=%0d/%0d", v, tens, ones, v / 10, v % 10);
      end
      checks++; if (warn !== exp_warn || blink !== exp_blink) begin
        failures++; $display("FAIL cd_warn_blink v=%0d got=%b%b exp=%b%b", v, warn, blink, exp_warn, exp_blink);
      end
    end
    checks++; if (over !== 1'b1) begin failures++; $display("FAIL cd_over got=%b exp=1", over); end
    checks++; if (over_pulse !== 1'b1) begin failures++; $display("FAIL cd_pulse got=%b exp=1", over_pulse); end
    checks++; if (elapsed !== 7'd40) begin failures++; $display("FAIL cd_elapsed got=%0d exp=40", elapsed); end
    checks++; if (proto_err !== 1'b0) begin failures++; $display("FAIL cd_proto got=%b exp=0", proto_err); end
  endtask

  task automatic test_over_hold;
    for (int i = 0; i < 5; i++) begin
      drive(0, 1'b1);
      checks++; if (over !== 1'b1 || over_pulse !== 1'b0 || elapsed !== 7'd40) begin
        failures++; $display("FAIL over_hold i=%0d got over=%b pulse=%b el=%0d exp 1/0/40", i, over, over_pulse, elapsed);
      end
    end
  endtask

  task automatic test_reload;
    drive(40, 1'b1);
    checks++; if (over !== 1'b0 || warn !== 1'b0 || over_pulse !== 1'b0) begin
      failures++; $display("FAIL reload_flags got over=%b warn=%b pulse=%b exp 0/0/0", over, warn, over_pulse);
    end
    checks++; if (elapsed !== 7'd0) begin failures++; $display("FAIL reload_elapsed got=%0d exp=0", elapsed); end
    checks++; if (proto_err !== 1'b0) begin failures++; $display("FAIL reload_proto got=%b exp=0", proto_err); end
    checks++; if (tens !== 4'd4 || ones !== 4'd0) begin
      failures++; $display("FAIL reload_bcd got=%0d/%0d exp=4/0", tens, ones);
    end
    drive(40, 1'b0);
  endtask

  task automatic test_proto_err;
    for (int v = 39; v >= 20; v--) drive(v, 1'b0);
    checks++; if (elapsed !== 7'd20 || proto_err !== 1'b0) begin
      failures++; $display("FAIL pe_pre got el=%0d pe=%b exp 20/0", elapsed, proto_err);
    end
    drive(17, 1'b0);
    checks++; if (proto_err !== 1'b1 || elapsed !== 7'd20) begin
      failures++; $display("FAIL pe_jump got pe=%b el=%0d exp 1/20", proto_err, elapsed);
    end
    for (int v = 16; v >= 0; v--) begin
      drive(v, 1'b0);
      checks++; if (proto_err !== 1'b1) begin failures++; $display("FAIL pe_sticky v=%0d got=%b exp=1", v, proto_err); end
    end
    checks++; if (over !== 1'b1 || over_pulse !== 1'b0 || elapsed !== 7'd37) begin
      failures++; $display("FAIL pe_zero got over=%b pulse=%b el=%0d exp 1/0/37", over, over_pulse, elapsed);
    end
    drive(0, 1'b1);
    checks++; if (over_pulse !== 1'b1) begin failures++; $display("FAIL pe_late_pulse got=%b exp=1", over_pulse); end
    drive(0, 1'b1);
    checks++; if (over_pulse !== 1'b0) begin failures++; $display("FAIL pe_pulse_once got=%b exp=0", over_pulse); end
    rst = 1'b1;
    drive(40, 1'b0);
    rst = 1'b0;
    checks++; if (proto_err !== 1'b0 || over !== 1'b0) begin
      failures++; $display("FAIL pe_rst_clear got pe=%b over=%b exp 0/0", proto_err, over);
    end
  endtask

  task automatic test_reset_in_warn;
    for (int v = 39; v >= 5; v--) drive(v, 1'b0);
    checks++; if (warn !== 1'b1 || blink !== 1'b1) begin
      failures++; $display("FAIL rw_pre got warn=%b blink=%b exp 1/1", warn, blink);
    end
    rst = 1'b1;
    drive(5, 1'b0);
    rst = 1'b0;
    checks++; if (warn !== 1'b0 || blink !== 1'b0 || over !== 1'b0) begin
      failures++; $display("FAIL rw_flags got warn=%b blink=%b over=%b exp 0/0/0", warn, blink, over);
    end
    checks++; if (tens !== 4'd4 || ones !== 4'd0 || elapsed !== 7'd0) begin
      failures++; $display("FAIL rw_vals got=%0d/%0d el=%0d exp 4/0 el=0", tens, ones, elapsed);
    end
    drive(40, 1'b0);
    checks++; if (proto_err !== 1'b0) begin failures++; $display("FAIL rw_proto got=%b exp=0", proto_err); end
  endtask

  task automatic test_hold;
    for (int v = 39; v >= 30; v--) drive(v, 1'b0);
    for (int i = 0; i < 8; i++) begin
      drive(30, 1'b0);
      checks++; if (elapsed !== 7'd10 || warn !== 1'b0 || proto_err !== 1'b0 || tens !== 4'd3 || ones !== 4'd0) begin
        failures++; $display("FAIL hold i=%0d got el=%0d warn=%b pe=%b bcd=%0d/%0d exp 10/0/0 3/0",
                             i, elapsed, warn, proto_err, tens, ones);
      end
    end
  endtask

  initial begin
    test_reset;
    test_countdown;
    test_over_hold;
    test_reload;
    test_proto_err;
    test_reset_in_warn;
    test_hold;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
